// File: rtl/ula_ar_arb.sv
// Round-robin arbiter that shares one combinational ULA between two requesters.
// Each operation is granted in IDLE, executed in EXEC and acknowledged with a one-cycle DONE in RESP.
module ula_ar_arb #(
   parameter int BITS = 8
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            req0_i,
   input  logic            req1_i,
   input  logic [4:0]      op0_i,
   input  logic [4:0]      op1_i,
   input  logic [BITS-1:0] a0_i,
   input  logic [BITS-1:0] b0_i,
   input  logic [BITS-1:0] a1_i,
   input  logic [BITS-1:0] b1_i,
   output logic            done0_o,
   output logic            done1_o,
   output logic [BITS-1:0] resu_o,
   output logic            o_o,
   output logic            c_o,
   output logic            s_o,
   output logic            z_o,
   output logic            err_o,
   output logic            busy_o,
   output logic [BITS-1:0] ula_a_o,
   output logic [BITS-1:0] ula_b_o,
   output logic [4:0]      ula_op_o,
   input  logic [BITS-1:0] ula_resu_i,
   input  logic            ula_o_i,
   input  logic            ula_c_i,
   input  logic            ula_s_i,
   input  logic            ula_z_i
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic            gnt_q, gnt_d;
   logic            last_q, last_d;
   logic [BITS-1:0] ulaA_q, ulaA_d;
   logic [BITS-1:0] ulaB_q, ulaB_d;
   logic [4:0]      ulaOp_q, ulaOp_d;
   logic [BITS-1:0] resu_q, resu_d;
   logic            o_q, o_d, c_q, c_d, s_q, s_d, z_q, z_d;
   logic            err_q, err_d;
   logic            done0_q, done0_d, done1_q, done1_d;
   logic            busy_q, busy_d;
   logic            opSupported;

   always_comb begin
      opSupported = 1'b0;
      case (ulaOp_q)
         5'b00000, 5'b00001, 5'b00011,
         5'b00100, 5'b00101, 5'b00110: opSupported = 1'b1;
         default:                      opSupported = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      ulaA_d  = ulaA_q;
      ulaB_d  = ulaB_q;
      ulaOp_d = ulaOp_q;
      resu_d  = resu_q;
      o_d     = o_q;
      c_d     = c_q;
      s_d     = s_q;
      z_d     = z_q;
      err_d   = err_q;
      done0_d = 1'b0;
      done1_d = 1'b0;
      busy_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req0_i || req1_i) begin
               // On a tie the requester served least recently wins.
               gnt_d   = (req0_i && req1_i) ? ~last_q : req1_i;
               ulaA_d  = gnt_d ? a1_i  : a0_i;
               ulaB_d  = gnt_d ? b1_i  : b0_i;
               ulaOp_d = gnt_d ? op1_i : op0_i;
               state_d = EXEC;
               busy_d  = 1'b1;
            end
         end
         EXEC: begin
            if (opSupported) begin
               resu_d = ula_resu_i;
               o_d    = ula_o_i;
               c_d    = ula_c_i;
               s_d    = ula_s_i;
               z_d    = ula_z_i;
               err_d  = 1'b0;
            end else begin
               resu_d = '0;
               o_d    = 1'b0;
               c_d    = 1'b0;
               s_d    = 1'b0;
               z_d    = 1'b0;
               err_d  = 1'b1;
            end
            done0_d = ~gnt_q;
            done1_d = gnt_q;
            last_d  = gnt_q;
            state_d = RESP;
            busy_d  = 1'b1;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         gnt_q   <= 1'b0;
         last_q  <= 1'b1;
         ulaA_q  <= '0;
         ulaB_q  <= '0;
         ulaOp_q <= '0;
         resu_q  <= '0;
         o_q     <= 1'b0;
         c_q     <= 1'b0;
         s_q     <= 1'b0;
         z_q     <= 1'b0;
         err_q   <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         ulaA_q  <= ulaA_d;
         ulaB_q  <= ulaB_d;
         ulaOp_q <= ulaOp_d;
         resu_q  <= resu_d;
         o_q     <= o_d;
         c_q     <= c_d;
         s_q     <= s_d;
         z_q     <= z_d;
         err_q   <= err_d;
         done0_q <= done0_d;
         done1_q <= done1_d;
         busy_q  <= busy_d;
      end
   end

   assign done0_o  = done0_q;
   assign done1_o  = done1_q;
   assign resu_o   = resu_q;
   assign o_o      = o_q;
   assign c_o      = c_q;
   assign s_o      = s_q;
   assign z_o      = z_q;
   assign err_o    = err_q;
   assign busy_o   = busy_q;
   assign ula_a_o  = ulaA_q;
   assign ula_b_o  = ulaB_q;
   assign ula_op_o = ulaOp_q;

endmodule

// File: doc/ula_ar_arb.md
# ula_ar_arb

Two-port round-robin arbiter and sequencer for one shared arithmetic-only ULA instance. It accepts operation requests (operands plus 5-bit opcode) from two independent requesters and drives the ULA's A/B/OP inputs from registers. It captures the ULA result and O/C/S/Z flags into output registers and returns them with a one-cycle completion strobe. It sits between the datapath requesters (for example, the execute stage and an address/increment unit) and the single ULA instance.

## Interface
- BITS, 8, data width; the attached ULA instance is parameterized with the same value.

- CLK  in  1  system clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- REQ0 / REQ1  in  1  request from requester 0 / 1; held high until the matching DONE
- OP0 / OP1  in  5  opcode of requester 0 / 1
- A0, B0 / A1, B1  in  BITS  signed operands of requester 0 / 1
- DONE0 / DONE1  out  1  one-cycle completion strobe to requester 0 / 1
- RESU  out  BITS  registered result of the last completed operation
- O, C, S, Z  out  1 each  registered overflow, carry, sign and zero flags of the last completed operation
- ERR  out  1  registered; last completed operation had an unsupported opcode
- BUSY  out  1  high while the FSM is not IDLE
- ULA_A, ULA_B  out  BITS  registered operands to the ULA
- ULA_OP  out  5  registered opcode to the ULA
- ULA_RESU  in  BITS  ULA result (combinational from ULA_A/ULA_B/ULA_OP)
- ULA_O, ULA_C, ULA_S, ULA_Z  in  1 each  ULA flags

## Operation
- Supported opcodes: 00000 A+B, 00001 A+B+1, 00011 A+1, 00100 A-B-1, 00101 A-B, 00110 A-1. Every other opcode is unsupported.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE, no REQ high: stay in IDLE, BUSY=0. ULA_A, ULA_B and ULA_OP hold their last values.
- IDLE, at least one REQ high: grant one requester.
  - If only one REQ is high, that requester is granted.
  - If both are high, grant the requester that is not LAST (round-robin).
  - Latch the granted A, B and OP into ULA_A, ULA_B and ULA_OP, record GNT, and go to EXEC.
- EXEC, supported opcode:
  - Capture ULA_RESU into RESU and ULA_O/C/S/Z into O/C/S/Z; set ERR=0.
  - Set DONE[GNT]=1, set LAST=GNT, and go to RESP.
- EXEC, unsupported opcode:
  - Set RESU=0, O=C=S=Z=0, ERR=1.
  - DONE, LAST and the transition to RESP behave as for a supported opcode.
- RESP: clear DONE and go to IDLE.
- Request handshake:
  - A requester keeps REQ, A, B and OP stable from raising REQ until it sees DONE.
  - It drops REQ on the edge that ends the DONE cycle.
  - A REQ still high in the IDLE cycle after RESP counts as a new request.
- RESU, O, C, S, Z and ERR hold their values until the next completion.
- A requester that drops REQ during EXEC is still served: its operation completes and DONE still pulses.
- The requester not granted waits. Because of round-robin, it is granted on the next IDLE cycle where it requests, so no starvation.
- Asynchronous reset (RST_N low):
  - FSM goes to IDLE.
  - All outputs are 0: DONE0, DONE1, RESU, O, C, S, Z, ERR, BUSY, ULA_A, ULA_B, ULA_OP.
  - LAST=1, so requester 0 wins the first tie.
  - Reset during EXEC or RESP aborts the operation; no DONE is issued.

## Timing
- Edge 0 (IDLE, REQ sampled high): operands latched; EXEC during cycle 1.
- Edge 1: result and flags captured; DONEx=1 during cycle 2 (RESP).
- Edge 2: DONE=0, state IDLE.
- Latency: 2 edges from request sample to DONE. A back-to-back request is next sampled at edge 3; peak throughput is one operation per 3 cycles.
- The ULA path is combinational from the ULA_* registers to the RESU capture registers, giving a single-cycle path within EXEC.
- BUSY is registered; it is high during the EXEC and RESP cycles.
- DONE0 and DONE1 are never high in the same cycle.

## Test plan
- Reset: hold RST_N=0 with random inputs -> all outputs 0. Release, then REQ0 and REQ1 both high -> requester 0 is granted first.
- Single add: BITS=8, REQ0 with A0=0x05, B0=0x03, OP0=00000 -> DONE0 two edges later; RESU=0x08, O=C=S=Z=0, ERR=0, DONE1 never asserts.
- Subtract sign: REQ1 with A1=0x03, B1=0x05, OP1=00101 -> DONE1; RESU=0xFE, S=1, Z=0. Then A1=0x7F, B1=0x7F, OP1=00101 -> RESU=0x00, Z=1.
- Contention: REQ0 and REQ1 held high continuously, each dropping only for the cycle after its DONE -> grant order 0,1,0,1; each DONE is exactly 3 cycles apart.
- Unsupported opcode: REQ0 with OP0=00010, A0=0x11 -> DONE0 with ERR=1, RESU=0, flags 0. The next supported operation clears ERR.
- Mid-operation reset: assert RST_N=0 during the EXEC cycle -> no DONE, outputs 0, BUSY=0. After release, a held REQ is re-served normally.
